// File: rtl/sys_bridge_tc_pkg.sv
// Shared definitions for the sys_bridge_tc data-bus responder and its timer/counters.
package sys_bridge_tc_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_3000;
    localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7f00;
    localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7f10;
    localparam logic [31:0] INTGEN_BASE  = 32'h0000_7f20;

    // Word slot 3 of each 16-byte timer window is unmapped.
    function automatic logic tc_hit(input logic [31:0] addr, input logic [27:0] base_hi);
        return (addr[31:4] == base_hi) && (addr[3:2] != 2'b11);
    endfunction

endpackage

// File: rtl/sys_bridge_tc_timer.sv
// tc_timer: one timer/counter with CTRL/PRESET/COUNT registers, 4-state FSM and registered irq.
module tc_timer
    import sys_bridge_tc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e   state_r, state_nxt_s;
    logic [3:0]  ctrl_r, ctrl_fsm_s, ctrl_nxt_s;
    logic [31:0] preset_r, preset_nxt_s;
    logic [31:0] count_r, count_nxt_s;
    logic        flag_r, flag_fsm_s, flag_nxt_s;
    logic        irq_r;
    logic        wr_ctrl_s, wr_preset_s;

    assign wr_ctrl_s   = wr_en && (reg_sel == REG_CTRL);
    assign wr_preset_s = wr_en && (reg_sel == REG_PRESET);

    // Bus writes take priority over the FSM; any CTRL write also clears the flag.
    assign ctrl_nxt_s   = wr_ctrl_s   ? wdata[3:0] : ctrl_fsm_s;
    assign flag_nxt_s   = wr_ctrl_s   ? 1'b0       : flag_fsm_s;
    assign preset_nxt_s = wr_preset_s ? wdata      : preset_r;

    // State and register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ctrl_r   <= 4'd0;
            preset_r <= 32'd0;
            count_r  <= 32'd0;
            flag_r   <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            preset_r <= preset_nxt_s;
            count_r  <= count_nxt_s;
            flag_r   <= flag_nxt_s;
            irq_r    <= flag_r & ctrl_r[CTRL_IM];
        end
    end

    // FSM next-state and counter datapath
    always_comb begin
        state_nxt_s = state_r;
        ctrl_fsm_s  = ctrl_r;
        count_nxt_s = count_r;
        flag_fsm_s  = flag_r;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[CTRL_EN]) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nxt_s = preset_r;
                state_nxt_s = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_r[CTRL_EN]) begin
                    state_nxt_s = ST_IDLE;
                end else if (count_r > 32'd1) begin
                    count_nxt_s = count_r - 32'd1;
                end else begin
                    count_nxt_s = 32'd0;
                    flag_fsm_s  = 1'b1;
                    state_nxt_s = ST_INT;
                end
            end
            ST_INT: begin
                // Modes 10/11 fall into the one-shot branch.
                if (ctrl_r[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
                    flag_fsm_s = 1'b0;
                end else begin
                    ctrl_fsm_s[CTRL_EN] = 1'b0;
                end
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Register read mux
    always_comb begin
        case (reg_sel)
            REG_CTRL:   rdata = {28'd0, ctrl_r};
            REG_PRESET: rdata = preset_r;
            REG_COUNT:  rdata = count_r;
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = irq_r;

endmodule

// File: rtl/sys_bridge_tc.sv
// sys_bridge_tc: M-stage data-bus decoder routing to data memory and two timers.
// Optional interrupt-generator window enabled by defining BRIDGE_INTGEN_EN.
module sys_bridge_tc
    import sys_bridge_tc_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEF,
    parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    output logic [31:0] int_addr,
    output logic [3:0]  int_byteen,
    output logic [1:0]  irq
);

    logic        dm_hit_s, tc0_hit_s, tc1_hit_s, wr_full_s;
    logic [31:0] tc0_rdata_s, tc1_rdata_s;

    assign dm_hit_s  = (cpu_addr < DM_LIMIT);
    assign tc0_hit_s = tc_hit(cpu_addr, TC0_BASE[31:4]);
    assign tc1_hit_s = tc_hit(cpu_addr, TC1_BASE[31:4]);
    assign wr_full_s = (cpu_byteen == 4'b1111);

    assign dm_addr   = cpu_addr;
    assign dm_wdata  = cpu_wdata;
    // Reset gates the strobe so no store leaks out while the core is held.
    assign dm_byteen = (reset && dm_hit_s) ? cpu_byteen : 4'b0000;

`ifdef BRIDGE_INTGEN_EN
    logic ig_wr_s;
    assign ig_wr_s    = reset && (cpu_addr[31:2] == INTGEN_BASE[31:2]) && (cpu_byteen != 4'b0000);
    assign int_addr   = ig_wr_s ? cpu_addr : 32'd0;
    assign int_byteen = ig_wr_s ? cpu_byteen : 4'b0000;
`else
    assign int_addr   = 32'd0;
    assign int_byteen = 4'b0000;
`endif

    tc_timer u_tc0 (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (tc0_hit_s && wr_full_s),
        .reg_sel (cpu_addr[3:2]),
        .wdata   (cpu_wdata),
        .rdata   (tc0_rdata_s),
        .irq     (irq[0])
    );

    tc_timer u_tc1 (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (tc1_hit_s && wr_full_s),
        .reg_sel (cpu_addr[3:2]),
        .wdata   (cpu_wdata),
        .rdata   (tc1_rdata_s),
        .irq     (irq[1])
    );

    // Combinational read-data select
    always_comb begin
        cpu_rdata = 32'd0;
        if (dm_hit_s) begin
            cpu_rdata = dm_rdata;
        end else if (tc0_hit_s) begin
            cpu_rdata = tc0_rdata_s;
        end else if (tc1_hit_s) begin
            cpu_rdata = tc1_rdata_s;
        end else begin
            cpu_rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_sys_bridge_tc.sv
// Directed self-checking bench for sys_bridge_tc with an expected-value queue.
module tb_sys_bridge_tc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_byteen;
    logic [31:0] int_addr;
    logic [3:0]  int_byteen;
    logic [1:0]  irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sys_bridge_tc dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_byteen (cpu_byteen),
        .cpu_rdata  (cpu_rdata),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_byteen  (dm_byteen),
        .dm_rdata   (dm_rdata),
        .int_addr   (int_addr),
        .int_byteen (int_byteen),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_q(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        cpu_addr   = addr;
        cpu_wdata  = data;
        cpu_byteen = be;
        @(posedge clk);
        #1;
        cpu_byteen = 4'b0000;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] expv);
        exp_q.push_back(expv);
        cpu_addr   = addr;
        cpu_byteen = 4'b0000;
        #1;
        check_q(tag, cpu_rdata);
    endtask

    task automatic chk_irq(input string tag, input logic [1:0] expv);
        exp_q.push_back({30'd0, expv});
        check_q(tag, {30'd0, irq});
    endtask

    initial begin
        reset      = 1'b0;
        cpu_addr   = 32'h0000_0000;
        cpu_wdata  = 32'h0000_0000;
        cpu_byteen = 4'b1111;
        dm_rdata   = 32'h0000_0000;

        // Reset state
        #2;
        check("rst_dm_byteen", {28'd0, dm_byteen}, 32'd0);
        chk_irq("rst_irq", 2'b00);
        tick();
        reset = 1'b1;
        #1;
        check("post_rst_dm_byteen", {28'd0, dm_byteen}, 32'h0000_000f);
        rd("rst_ctrl0", 32'h0000_7f00, 32'd0);
        rd("rst_count0", 32'h0000_7f08, 32'd0);
        tick();

        // TC0 one-shot, PRESET 5, IM on; PRESET rewritten mid-count
        wr(32'h0000_7f04, 32'd5, 4'b1111);
        wr(32'h0000_7f00, 32'h0000_0009, 4'b1111);
        chk_irq("tc0_irq_e0", 2'b00);
        repeat (3) tick();
        rd("tc0_count_e3", 32'h0000_7f08, 32'd4);
        wr(32'h0000_7f04, 32'd9, 4'b1111);
        rd("tc0_count_e4", 32'h0000_7f08, 32'd3);
        repeat (3) tick();
        chk_irq("tc0_irq_e7", 2'b00);
        tick();
        chk_irq("tc0_irq_e8", 2'b01);
        rd("tc0_count_done", 32'h0000_7f08, 32'd0);
        rd("tc0_ctrl_en_cleared", 32'h0000_7f00, 32'h0000_0008);
        repeat (4) tick();
        chk_irq("tc0_irq_hold", 2'b01);
        wr(32'h0000_7f00, 32'h0000_0000, 4'b1111);
        chk_irq("tc0_irq_wr_edge", 2'b01);
        tick();
        chk_irq("tc0_irq_dropped", 2'b00);

        // TC1 auto-reload, PRESET 2: pulse every 5 cycles
        wr(32'h0000_7f14, 32'd2, 4'b1111);
        wr(32'h0000_7f10, 32'h0000_000b, 4'b1111);
        for (int k = 1; k <= 15; k++) begin
            exp_q.push_back(((k % 5) == 0) ? 32'h0000_0002 : 32'h0000_0000);
        end
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_q($sformatf("tc1_pulse_k%0d", k), {30'd0, irq});
        end
        wr(32'h0000_7f10, 32'h0000_0000, 4'b1111);

        // Partial writes and COUNT writes are dropped
        wr(32'h0000_7f04, 32'h0000_ffff, 4'b0011);
        wr(32'h0000_7f08, 32'h0000_1234, 4'b1111);
        wr(32'h0000_7f00, 32'h0000_0001, 4'b0001);
        rd("partial_preset0", 32'h0000_7f04, 32'd9);
        rd("ro_count0", 32'h0000_7f08, 32'd0);
        rd("partial_ctrl0", 32'h0000_7f00, 32'd0);

        // DM forwarding and boundary
        tick();
        cpu_addr   = 32'h0000_2ffc;
        cpu_wdata  = 32'h0000_a5a5;
        cpu_byteen = 4'b1111;
        #1;
        check("dm_byteen_2ffc", {28'd0, dm_byteen}, 32'h0000_000f);
        check("dm_addr_2ffc", dm_addr, 32'h0000_2ffc);
        check("dm_wdata_2ffc", dm_wdata, 32'h0000_a5a5);
        cpu_addr = 32'h0000_3000;
        #1;
        check("dm_byteen_3000", {28'd0, dm_byteen}, 32'd0);
        cpu_byteen = 4'b0000;

        // Read decode
        dm_rdata = 32'hdead_beef;
        rd("rd_7f0c", 32'h0000_7f0c, 32'd0);
        rd("rd_8000", 32'h0000_8000, 32'd0);
        rd("rd_0010", 32'h0000_0010, 32'hdead_beef);
        rd("rd_3000", 32'h0000_3000, 32'd0);
        rd("rd_2ffc", 32'h0000_2ffc, 32'hdead_beef);

        // Interrupt-generator window
        tick();
        cpu_addr   = 32'h0000_7f21;
        cpu_wdata  = 32'h0000_ab00;
        cpu_byteen = 4'b0010;
        #1;
`ifdef BRIDGE_INTGEN_EN
        check("ig_byteen", {28'd0, int_byteen}, 32'h0000_0002);
        check("ig_addr", int_addr, 32'h0000_7f21);
`else
        check("ig_byteen", {28'd0, int_byteen}, 32'd0);
        check("ig_addr", int_addr, 32'd0);
`endif
        tick();
        cpu_byteen = 4'b0000;
        #1;
        check("ig_byteen_after", {28'd0, int_byteen}, 32'd0);
        rd("rd_7f20", 32'h0000_7f20, 32'd0);

        // Reset mid-run with irq asserted and TC1 counting
        wr(32'h0000_7f04, 32'd1, 4'b1111);
        wr(32'h0000_7f14, 32'd50, 4'b1111);
        wr(32'h0000_7f10, 32'h0000_0001, 4'b1111);
        wr(32'h0000_7f00, 32'h0000_0009, 4'b1111);
        repeat (4) tick();
        chk_irq("mid_irq_before", 2'b01);
        rd("mid_count1_before", 32'h0000_7f18, 32'd47);
        cpu_addr   = 32'h0000_0004;
        cpu_byteen = 4'b1111;
        #1;
        check("mid_dm_byteen_before", {28'd0, dm_byteen}, 32'h0000_000f);
        reset = 1'b0;
        #1;
        chk_irq("mid_irq_reset", 2'b00);
        check("mid_dm_byteen_reset", {28'd0, dm_byteen}, 32'd0);
        rd("mid_count0_reset", 32'h0000_7f08, 32'd0);
        rd("mid_count1_reset", 32'h0000_7f18, 32'd0);
        rd("mid_ctrl1_reset", 32'h0000_7f10, 32'd0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk_irq("mid_irq_after", 2'b00);
        rd("mid_count1_after", 32'h0000_7f18, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_bridge_tc.md
Name: sys_bridge_tc

Overview:
- Data-bus responder on the memory side of the pipelined CPU's M-stage interface.
- Decodes CPU addr/byteen/wdata and routes accesses to the external data memory or to two embedded timer/counters (TC0, TC1).
- Returns read data combinationally in the same cycle.
- Drives the two timer interrupt lines into the CPU's HWInt[1:0].

Parameters:
- DM_LIMIT, 32'h0000_3000, first address above data memory (DM = [0, DM_LIMIT)).
- TC0_BASE, 32'h0000_7f00, TC0 register base (CTRL +0, PRESET +4, COUNT +8).
- TC1_BASE, 32'h0000_7f10, TC1 register base, same layout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  32  byte address from CPU.
- cpu_wdata  in  32  lane-aligned write data.
- cpu_byteen  in  4  write byte enables; nonzero means write, 0 means read or idle.
- cpu_rdata  out  32  read data, combinational from cpu_addr.
- dm_addr  out  32  forwarded address.
- dm_wdata  out  32  forwarded write data.
- dm_byteen  out  4  cpu_byteen when the address hits DM, else 0.
- dm_rdata  in  32  data memory read data.
- int_addr  out  32  interrupt-generator address.
- int_byteen  out  4  interrupt-generator byte enables.
- irq  out  2  {TC1, TC0} interrupt requests.

Behaviour:
- Decode:
  - DM hit: cpu_addr < DM_LIMIT.
  - TCn hit: cpu_addr[31:4] == TCn_BASE[31:4] and cpu_addr[3:2] != 3.
  - Any other address: cpu_rdata = 0, writes ignored.
- cpu_rdata:
  - DM hit: dm_rdata.
  - TC hit: the addressed register (CTRL zero-extended from 4 bits).
- Timer register writes:
  - Accepted only when cpu_byteen == 4'b1111; partial writes are ignored.
  - CTRL and PRESET are writable. COUNT is read-only; writes to COUNT are dropped.
  - Writes are sampled on the rising clk edge.
- CTRL bits:
  - [0] EN.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 10/11 behave as 00.
  - [3] IM (interrupt mask enable).
- Reset (reset low, immediate):
  - CTRL, PRESET and COUNT = 0; state = IDLE; irq flags = 0.
  - irq = 2'b00; dm_byteen = 0; int_byteen = 0.
  - cpu_rdata follows decode only.
- Per-timer FSM (one transition per clk):
  - IDLE: if EN → LOAD.
  - LOAD: COUNT <= PRESET → CNT.
  - CNT, EN == 0: → IDLE, COUNT holds.
  - CNT, EN == 1 and COUNT > 1: COUNT <= COUNT - 1.
  - CNT, EN == 1 and COUNT <= 1: COUNT <= 0, set irq flag → INT.
  - INT, MODE 00: clear EN → IDLE; flag stays set until the next CTRL write.
  - INT, MODE 01: clear flag next cycle (1-cycle pulse) → IDLE. EN stays 1, so the timer reloads: period = PRESET + 3 cycles.
- irq[n] = flag[n] & CTRL[3]; registered, no combinational path from the bus.
- Simultaneous events:
  - A bus CTRL write in the same cycle as the FSM clearing EN: the bus write wins.
  - Any CTRL write clears the irq flag.
- PRESET written during CNT does not affect COUNT until the next LOAD.
- PRESET == 0 or 1: LOAD → CNT → INT, firing on the 3rd cycle after EN.
- Reset mid-count: all timer state returns to reset values immediately, with no residual irq.

Optional Feature:
- Macro: BRIDGE_INTGEN_EN.
- Defined: a write with any byteen to [0x7f20, 0x7f23] drives int_addr = cpu_addr and int_byteen = cpu_byteen for that cycle; reads there return 0.
- Undefined: int_addr = 0 and int_byteen = 0 permanently; the range decodes as unmapped.

Decomposition:
- Shared package:
  - TC register offsets (REG_CTRL 0, REG_PRESET 1, REG_COUNT 2).
  - CTRL bit indices.
  - MODE encodings.
  - FSM state encoding (IDLE, LOAD, CNT, INT; 2 bits).
  - Default base addresses.
- Sub-module: tc_timer, holding the registers, FSM and irq, instantiated twice. The bridge itself stays decode-and-mux only.

Test Plan:
- Reset low mid-run → irq = 00, TC0 COUNT reads 0 at 0x7f08, dm_byteen = 0 immediately.
- Write PRESET0 = 5, then CTRL0 = 4'b1001 → COUNT loads 5 and reaches 0; irq[0] rises 8 cycles after the CTRL write and holds; writing CTRL0 = 0 drops irq[0] next cycle.
- CTRL1 = 4'b1011, PRESET1 = 2 → irq[1] pulses 1 cycle wide every 5 cycles while EN = 1.
- Store byteen = 4'b0011 to 0x7f04, then sw 0x1234 to 0x7f08 → PRESET and COUNT unchanged. Store to 0x2ffc → dm_byteen = 1111, dm_addr = 0x2ffc.
- Read 0x7f0c and 0x8000 → cpu_rdata = 0. Read 0x0010 with dm_rdata = 0xdeadbeef → cpu_rdata = 0xdeadbeef.
- With BRIDGE_INTGEN_EN: sb to 0x7f21 → int_byteen = 0010 for one cycle. Without the macro → int_byteen stays 0.
